// File: rtl/vga_pixclk_gen.sv
// Multi-channel phase-accumulator pixel clock-enable generator with runtime
// reprogramming over a valid/ready handshake and a settle-counter lock flag.
module vga_pixclk_gen #(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned ACC_W       = 32,
    parameter int unsigned LOCK_CYCLES = 64,
    parameter logic [NUM_CH*ACC_W-1:0] INC_INIT = {NUM_CH{32'd2859543971}},
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst,
    output logic [NUM_CH-1:0] outclk,
    output logic [NUM_CH-1:0] ce,
    output logic              locked,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    output logic              cfg_err
);

    localparam int unsigned CNT_W = $clog2(LOCK_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    typedef enum logic {StSettle, StRun} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              locked_q, locked_d;
    logic              cfg_err_q, cfg_err_d;
    logic              cfg_xfer, ch_ok;

    logic [ACC_W-1:0]  acc_q [NUM_CH];
    logic [ACC_W-1:0]  inc_q [NUM_CH];
    logic [ACC_W:0]    sum   [NUM_CH];
    logic [NUM_CH-1:0] sel;
    logic [NUM_CH-1:0] ce_q, outclk_q;

    // cfg_ready is the registered RUN flag, so transfers only happen in RUN
    assign cfg_xfer = cfg_valid && locked_q;
    assign ch_ok    = (32'(cfg_ch) < NUM_CH);

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q <= StSettle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StSettle: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = StRun;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (cfg_xfer && ch_ok) begin
                    state_d = StSettle;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StSettle;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        locked_d  = (state_d == StRun);
        cfg_err_d = cfg_xfer && !ch_ok;
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            locked_q  <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            locked_q  <= locked_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            sum[k] = {1'b0, acc_q[k]} + {1'b0, inc_q[k]};
            sel[k] = cfg_xfer && ch_ok && (cfg_ch == CH_W'(k));
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                acc_q[k]    <= '0;
                inc_q[k]    <= INC_INIT[k*ACC_W +: ACC_W];
                ce_q[k]     <= 1'b0;
                outclk_q[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (sel[k]) begin
                    // restart phase so the new rate begins from a known point
                    inc_q[k]    <= cfg_inc;
                    acc_q[k]    <= '0;
                    ce_q[k]     <= 1'b0;
                    outclk_q[k] <= 1'b0;
                end else begin
                    acc_q[k]    <= sum[k][ACC_W-1:0];
                    ce_q[k]     <= sum[k][ACC_W];
                    outclk_q[k] <= sum[k][ACC_W-1];
                end
            end
        end
    end

    assign outclk    = outclk_q;
    assign ce        = ce_q;
    assign locked    = locked_q;
    assign cfg_ready = locked_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_vga_pixclk_gen.sv
// Randomized bench for vga_pixclk_gen against an arithmetic phase/lock model.
module tb_vga_pixclk_gen;

    localparam int unsigned NUM_CH      = 3;
    localparam int unsigned ACC_W       = 4;
    localparam int unsigned LOCK_CYCLES = 4;
    localparam logic [11:0] INC_INIT    = 12'hB34;  // ch0=4, ch1=3, ch2=11
    localparam int          MODULUS     = 16;

    logic              refclk = 1'b0;
    logic              rst    = 1'b1;
    logic [NUM_CH-1:0] outclk, ce;
    logic              locked, cfg_ready, cfg_err;
    logic              cfg_valid = 1'b0;
    logic [1:0]        cfg_ch    = '0;
    logic [ACC_W-1:0]  cfg_inc   = '0;

    vga_pixclk_gen #(
        .NUM_CH     (NUM_CH),
        .ACC_W      (ACC_W),
        .LOCK_CYCLES(LOCK_CYCLES),
        .INC_INIT   (INC_INIT)
    ) dut (
        .refclk   (refclk),
        .rst      (rst),
        .outclk   (outclk),
        .ce       (ce),
        .locked   (locked),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_inc  (cfg_inc),
        .cfg_err  (cfg_err)
    );

    always #5 refclk = ~refclk;

    int n_tests = 0;
    int n_fail  = 0;

    int          m_acc [NUM_CH];
    int          m_inc [NUM_CH];
    int          since;
    logic [NUM_CH-1:0] e_ce, e_outclk;
    logic        e_locked, e_err;
    logic        last_xfer;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) begin
            m_acc[k] = 0;
            m_inc[k] = int'(INC_INIT[k*ACC_W +: ACC_W]);
        end
        since     = 0;
        e_ce      = '0;
        e_outclk  = '0;
        e_locked  = 1'b0;
        e_err     = 1'b0;
        last_xfer = 1'b0;
    endtask

    task automatic check_outs(input string tag);
        check({tag, "_ce"},     32'(ce),     32'(e_ce));
        check({tag, "_outclk"}, 32'(outclk), 32'(e_outclk));
        check({tag, "_locked"}, 32'(locked), 32'(e_locked));
        check({tag, "_ready"},  32'(cfg_ready), 32'(e_locked));
        check({tag, "_err"},    32'(cfg_err), 32'(e_err));
    endtask

    // One refclk edge: advance the model from the inputs held across the edge
    task automatic step();
        logic xfer;
        logic hit;
        int   ch, s;
        @(posedge refclk);
        xfer  = cfg_valid && e_locked;
        ch    = int'(cfg_ch);
        hit   = 1'b0;
        e_err = xfer && (ch >= NUM_CH);
        for (int k = 0; k < NUM_CH; k++) begin
            if (xfer && ch == k) begin
                m_inc[k]    = int'(cfg_inc);
                m_acc[k]    = 0;
                e_ce[k]     = 1'b0;
                e_outclk[k] = 1'b0;
                hit         = 1'b1;
            end else begin
                s           = m_acc[k] + m_inc[k];
                e_ce[k]     = (s >= MODULUS);
                m_acc[k]    = s % MODULUS;
                e_outclk[k] = (m_acc[k] >= MODULUS / 2);
            end
        end
        if (hit) since = 0;
        else if (since < 1000) since++;
        e_locked  = (since >= LOCK_CYCLES);
        last_xfer = xfer;
        #1;
        check_outs("run");
    endtask

    // Reset asserted between edges must clear outputs without a clock
    task automatic async_reset();
        #2;
        rst       = 1'b1;
        cfg_valid = 1'b0;
        #1;
        model_reset();
        check_outs("async");
        @(posedge refclk);
        @(posedge refclk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int cnt1, first0;
        model_reset();
        repeat (3) @(posedge refclk);
        #1;
        check_outs("rst");
        rst = 1'b0;

        cnt1   = 0;
        first0 = 0;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (ce[1]) cnt1++;
            if (ce[0] && first0 == 0) first0 = i;
        end
        check("ce1_count16", 32'(cnt1), 32'd3);
        check("first_ce0", 32'(first0), 32'd4);

        // out-of-range channel while running
        cfg_valid = 1'b1;
        cfg_ch    = 2'd3;
        cfg_inc   = 4'd5;
        step();
        check("err_pulse", 32'(cfg_err), 32'd1);
        cfg_valid = 1'b0;
        step();

        // reprogram ch1 to half-rate, then queue a request during SETTLE
        cfg_valid = 1'b1;
        cfg_ch    = 2'd1;
        cfg_inc   = 4'd8;
        step();
        check("xfer_unlock", 32'(locked), 32'd0);
        cfg_ch  = 2'd2;
        cfg_inc = 4'd5;
        for (int i = 0; i < 6; i++) begin
            step();
            if (last_xfer) cfg_valid = 1'b0;
        end

        // reset during SETTLE after a reconfiguration
        cfg_valid = 1'b1;
        cfg_ch    = 2'd0;
        cfg_inc   = 4'd7;
        step();
        cfg_valid = 1'b0;
        step();
        async_reset();
        for (int i = 0; i < 8; i++) step();

        for (int i = 0; i < 600; i++) begin
            if (!cfg_valid && $urandom_range(7) == 0) begin
                cfg_valid = 1'b1;
                cfg_ch    = 2'($urandom_range(3));
                cfg_inc   = 4'($urandom_range(15));
            end
            step();
            if (last_xfer) cfg_valid = 1'b0;
            if ($urandom_range(149) == 0) async_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
